title_animator: RTL and testbench

Frame-synchronous controller that sequences the on-screen title sprite. It produces a dynamic title origin (x, y) and a visibility flag, which feed the title colorizer's margin subtraction and its output gating. All updates occur only at the start of vertical blanking, so the title never tears mid-frame. It sits between the display timing generator (dtg) and the title colorizer in the VGA pipeline.

---
 rtl/title_pkg.sv | 19 +
 rtl/bounce_axis.sv | 39 +++
 rtl/title_animator.sv | 181 ++++++++++++++++++
 tb/tb_title_animator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/title_pkg.sv
// Shared definitions for the title animator: FSM states and screen/sprite geometry.
package title_pkg;

  typedef enum logic [1:0] {
    HOME = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int TITLE_WIDTH   = 256;
  localparam int TITLE_HEIGHT  = 128;

  // Largest origin that keeps the whole sprite on screen.
  localparam int X_MAX = SCREEN_WIDTH - TITLE_WIDTH;
  localparam int Y_MAX = SCREEN_HEIGHT - TITLE_HEIGHT;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing title: steps the position and reflects it at 0 and max.
module bounce_axis #(
  parameter int STEP = 2
) (
  input  logic [10:0] pos_i,
  input  logic        dir_i,      // 1 = increasing, 0 = decreasing
  input  logic        step_en_i,
  input  logic [10:0] max_i,
  output logic [10:0] pos_o,
  output logic        dir_o,
  output logic        hit_o
);

  logic [11:0] sum;

  // 12-bit step so a move below zero shows up in bit 11; touching an edge
  // counts as a bounce, overshooting it is clamped back onto the edge.
  always_comb begin
    sum   = dir_i ? ({1'b0, pos_i} + 12'(STEP)) : ({1'b0, pos_i} - 12'(STEP));
    pos_o = pos_i;
    dir_o = dir_i;
    hit_o = 1'b0;
    if (step_en_i) begin
      pos_o = sum[10:0];
      if (dir_i) begin
        if (sum >= {1'b0, max_i}) begin
          pos_o = max_i;
          dir_o = 1'b0;
          hit_o = 1'b1;
        end
      end else if (sum[11] || (sum == 12'd0)) begin
        pos_o = 11'd0;
        dir_o = 1'b1;
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/title_animator.sv
// Frame-synchronous title sprite sequencer: parks, bounces and blinks the title,
// updating only at the start of vertical blanking so the sprite never tears.
module title_animator
  import title_pkg::*;
#(
  parameter int HOME_X       = 384,
  parameter int HOME_Y       = 32,
  parameter int STEP         = 2,
  parameter int HOLD_FRAMES  = 30,
  parameter int BLINK_FRAMES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] pixel_row,
  input  logic signed [31:0] pixel_column,
  input  logic               anim_en,
  input  logic               blink_en,
  input  logic [3:0]         speed,
  output logic signed [31:0] title_x,
  output logic signed [31:0] title_y,
  output logic               title_visible,
  output logic               frame_tick,
  output logic [1:0]         state_o
);

  localparam int HOLD_W  = $clog2(HOLD_FRAMES);
  localparam int BLINK_W = $clog2(BLINK_FRAMES);

  logic in_vblank_q, in_vblank_dly_q, frame_tick_q;

  state_e               state_q, state_d;
  logic [10:0]          x_q, x_d, y_q, y_d;
  logic                 dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [3:0]           div_cnt_q, div_cnt_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 visible_q, visible_d;

  logic        step_en;
  logic [10:0] x_next, y_next;
  logic        dir_x_next, dir_y_next, hit_x, hit_y;

  // Only the row matters for blanking detection.
  logic unused_column;
  assign unused_column = ^pixel_column;

  // A move happens on a frame tick in MOVE when the divider has run out.
  assign step_en = frame_tick_q && (state_q == MOVE) && anim_en && (div_cnt_q == speed);

  bounce_axis #(.STEP(STEP)) u_axis_x (
    .pos_i(x_q), .dir_i(dir_x_q), .step_en_i(step_en), .max_i(11'(X_MAX)),
    .pos_o(x_next), .dir_o(dir_x_next), .hit_o(hit_x)
  );

  bounce_axis #(.STEP(STEP)) u_axis_y (
    .pos_i(y_q), .dir_i(dir_y_q), .step_en_i(step_en), .max_i(11'(Y_MAX)),
    .pos_o(y_next), .dir_o(dir_y_next), .hit_o(hit_y)
  );

  // Rising-edge detect of vertical blanking, registered into a one-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_vblank_q     <= 1'b0;
      in_vblank_dly_q <= 1'b0;
      frame_tick_q    <= 1'b0;
    end else begin
      in_vblank_q     <= (pixel_row >= SCREEN_HEIGHT);
      in_vblank_dly_q <= in_vblank_q;
      frame_tick_q    <= in_vblank_q & ~in_vblank_dly_q;
    end
  end

  // Animation state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOME;
      x_q         <= 11'(HOME_X);
      y_q         <= 11'(HOME_Y);
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      div_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      div_cnt_q   <= div_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
    end
  end

  // Next-state logic; everything holds except on a frame tick.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    div_cnt_d   = div_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;

    if (frame_tick_q) begin
      unique case (state_q)
        HOME: begin
          x_d = 11'(HOME_X);
          y_d = 11'(HOME_Y);
          if (anim_en) begin
            state_d   = MOVE;
            div_cnt_d = '0;
          end
        end
        MOVE: begin
          if (!anim_en) begin
            state_d = HOME;
            x_d     = 11'(HOME_X);
            y_d     = 11'(HOME_Y);
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
          end else if (div_cnt_q == speed) begin
            div_cnt_d = '0;
            x_d       = x_next;
            y_d       = y_next;
            dir_x_d   = dir_x_next;
            dir_y_d   = dir_y_next;
            // A corner hit flips both axes but still costs a single pause.
            if (hit_x || hit_y) begin
              state_d    = HOLD;
              hold_cnt_d = '0;
            end
          end else if (div_cnt_q > speed) begin
            // speed dropped below the running count; restart rather than stall.
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 4'd1;
          end
        end
        HOLD: begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (!anim_en) begin
            state_d = HOME;
            x_d     = 11'(HOME_X);
            y_d     = 11'(HOME_Y);
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
          end else if (hold_cnt_q == HOLD_W'(HOLD_FRAMES - 1)) begin
            state_d   = MOVE;
            div_cnt_d = '0;
          end
        end
        default: state_d = HOME;
      endcase

      if (blink_en) begin
        if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          visible_d   = ~visible_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end else begin
        blink_cnt_d = '0;
        visible_d   = 1'b1;
      end
    end
  end

  assign title_x       = {21'd0, x_q};
  assign title_y       = {21'd0, y_q};
  assign title_visible = visible_q;
  assign frame_tick    = frame_tick_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_title_animator.sv
// Directed bench for title_animator; a second instance parked next to the
// bottom-right corner exercises the simultaneous two-axis bounce.
module tb_title_animator;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] pixel_row = 0;
  logic signed [31:0] pixel_column = 0;
  logic               anim_en = 1'b0;
  logic               blink_en = 1'b0;
  logic [3:0]         speed = 4'd0;

  logic signed [31:0] title_x, title_y;
  logic               title_visible, frame_tick;
  logic [1:0]         state_o;

  logic signed [31:0] c_x, c_y;
  logic               c_vis_unused, c_tick_unused;
  logic [1:0]         c_state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  title_animator dut (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .anim_en(anim_en), .blink_en(blink_en), .speed(speed),
    .title_x(title_x), .title_y(title_y), .title_visible(title_visible),
    .frame_tick(frame_tick), .state_o(state_o)
  );

  title_animator #(.HOME_X(382), .HOME_Y(350)) dut_c (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .anim_en(anim_en), .blink_en(blink_en), .speed(speed),
    .title_x(c_x), .title_y(c_y), .title_visible(c_vis_unused),
    .frame_tick(c_tick_unused), .state_o(c_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Short frames: two active rows then three blanking cycles; returns after the
  // tick's update edge so the outputs already show the new frame state.
  task automatic tick_frame(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_row = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      pixel_row = 480;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int ticks;
    int tick_at;

    repeat (2) @(posedge clk);
    #1;
    check("rst_x", title_x, 384);
    check("rst_y", title_y, 32);
    check("rst_vis", 32'(title_visible), 1);
    check("rst_state", 32'(state_o), 0);
    check("rst_tick", 32'(frame_tick), 0);
    reset = 1'b0;

    // Full dtg frame, one row per clock.
    ticks   = 0;
    tick_at = -1;
    for (int r = 0; r < 525; r++) begin
      pixel_row    = r;
      pixel_column = r;
      @(posedge clk); #1;
      if (frame_tick) begin
        ticks++;
        tick_at = r;
      end
    end
    check("ticks_per_frame", 32'(ticks), 1);
    check("tick_row", 32'(tick_at), 481);
    check("home_x", title_x, 384);
    check("home_y", title_y, 32);
    check("home_state", 32'(state_o), 0);

    // Start bouncing from home at full speed.
    anim_en = 1'b1;
    tick_frame(1);
    check("go_state", 32'(state_o), 1);
    check("go_x", title_x, 384);
    tick_frame(1);
    check("bnc_x", title_x, 384);
    check("bnc_y", title_y, 34);
    check("bnc_state", 32'(state_o), 2);
    check("corner_x", c_x, 384);
    check("corner_y", c_y, 352);
    check("corner_state", 32'(c_state), 2);
    tick_frame(29);
    check("hold29_state", 32'(state_o), 2);
    check("hold29_cstate", 32'(c_state), 2);
    check("hold29_y", title_y, 34);
    tick_frame(1);
    check("hold30_state", 32'(state_o), 1);
    check("hold30_cstate", 32'(c_state), 1);
    tick_frame(1);
    check("mv1_x", title_x, 382);
    check("mv1_y", title_y, 36);
    check("corner_back_x", c_x, 382);
    check("corner_back_y", c_y, 350);
    tick_frame(1);
    check("mv2_x", title_x, 380);
    check("mv2_y", title_y, 38);

    // Divider: one move per speed+1 ticks, and a speed drop must not stall.
    speed = 4'd3;
    tick_frame(3);
    check("spd3_wait_x", title_x, 380);
    tick_frame(1);
    check("spd3_move_x", title_x, 378);
    check("spd3_move_y", title_y, 40);
    tick_frame(3);
    check("spd3_cnt3_x", title_x, 378);
    speed = 4'd1;
    tick_frame(2);
    check("spd1_clr_x", title_x, 378);
    tick_frame(1);
    check("spd1_move_x", title_x, 376);

    // Park, then blink.
    speed   = 4'd0;
    anim_en = 1'b0;
    tick_frame(1);
    check("park_state", 32'(state_o), 0);
    check("park_x", title_x, 384);
    check("park_y", title_y, 32);
    blink_en = 1'b1;
    tick_frame(14);
    check("blink14", 32'(title_visible), 1);
    tick_frame(1);
    check("blink15", 32'(title_visible), 0);
    tick_frame(14);
    check("blink29", 32'(title_visible), 0);
    tick_frame(1);
    check("blink30", 32'(title_visible), 1);
    tick_frame(15);
    check("blink45", 32'(title_visible), 0);
    blink_en = 1'b0;
    tick_frame(1);
    check("blink_off", 32'(title_visible), 1);

    // Drop anim_en while holding.
    anim_en = 1'b1;
    tick_frame(2);
    check("hold_again", 32'(state_o), 2);
    tick_frame(5);
    anim_en = 1'b0;
    tick_frame(1);
    check("drop_state", 32'(state_o), 0);
    check("drop_x", title_x, 384);
    check("drop_y", title_y, 32);
    anim_en = 1'b1;
    tick_frame(2);
    check("drop_dir_state", 32'(state_o), 2);
    check("drop_dir_y", title_y, 34);

    // Reset mid-frame while moving.
    tick_frame(30);
    tick_frame(1);
    check("pre_rst_x", title_x, 382);
    check("pre_rst_state", 32'(state_o), 1);
    pixel_row = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_x", title_x, 384);
    check("mrst_y", title_y, 32);
    check("mrst_state", 32'(state_o), 0);
    check("mrst_tick", 32'(frame_tick), 0);
    reset = 1'b0;
    tick_frame(2);
    check("mrst_dir_x", title_x, 384);
    check("mrst_dir_y", title_y, 34);
    check("mrst_dir_state", 32'(state_o), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
